// File: rtl/i2c_csr_regs.sv
// CSR block for the I2C core: control/status/prescale registers plus TX command and RX byte FIFOs.
// Define I2C_CSR_IRQ_EN to build the registered interrupt output and the CONTROL[3] irq_en bit.
module i2c_csr_regs #(
  parameter int unsigned ADD_WIDTH       = 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [ADD_WIDTH-1:0] bram_addr,
  input  logic                 bram_wr,
  input  logic [31:0]          bram_wr_data,
  input  logic                 bram_rd,
  output logic [31:0]          bram_rd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [11:0]          cmd_data,
  input  logic                 rsp_valid,
  input  logic [7:0]           rsp_data,
  input  logic                 engine_busy,
  output logic                 core_en,
  output logic [15:0]          prescale,
  output logic                 irq
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    REG_CONTROL  = 3'd0,
    REG_STATUS   = 3'd1,
    REG_PRESCALE = 3'd2,
    REG_TXDATA   = 3'd3,
    REG_RXDATA   = 3'd4,
    REG_LEVEL    = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_sel_e;

  reg_sel_e sel;
  logic     rd_en, ctrl_wr, status_wr, prescale_wr;
  logic     irq_en;
  logic     tx_ovf, rx_ovf;
  logic     unused_bits;

  logic [11:0]                tx_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] tx_wp, tx_rp;
  logic [CW-1:0]              tx_cnt;
  logic                       tx_empty, tx_full, tx_clr, tx_push, tx_push_ok, tx_pop;

  logic [7:0]                 rx_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rx_wp, rx_rp;
  logic [CW-1:0]              rx_cnt;
  logic                       rx_empty, rx_full, rx_clr, rx_push_ok, rx_pop;

  logic [31:0] rd_mux;

  assign sel         = reg_sel_e'(bram_addr[4:2]);
  // A write in the same cycle as a read wins; the read is dropped entirely.
  assign rd_en       = bram_rd & ~bram_wr;
  assign ctrl_wr     = bram_wr && (sel == REG_CONTROL);
  assign status_wr   = bram_wr && (sel == REG_STATUS);
  assign prescale_wr = bram_wr && (sel == REG_PRESCALE);

  assign tx_empty   = (tx_cnt == '0);
  assign tx_full    = (tx_cnt == FULL_CNT);
  assign tx_clr     = ctrl_wr & bram_wr_data[1];
  assign tx_push    = bram_wr && (sel == REG_TXDATA);
  assign tx_push_ok = tx_push & ~tx_full;
  assign tx_pop     = cmd_valid & cmd_ready;
  assign cmd_valid  = ~tx_empty;
  assign cmd_data   = tx_mem[tx_rp];

  assign rx_empty   = (rx_cnt == '0);
  assign rx_full    = (rx_cnt == FULL_CNT);
  assign rx_clr     = ctrl_wr & bram_wr_data[2];
  assign rx_push_ok = rsp_valid & ~rx_full;
  assign rx_pop     = rd_en && (sel == REG_RXDATA) && !rx_empty;

  always_comb begin
    rd_mux = '0;
    unique case (sel)
      REG_CONTROL:  rd_mux = {28'b0, irq_en, 2'b00, core_en};
      REG_STATUS:   rd_mux = {25'b0, tx_ovf, rx_ovf, engine_busy, rx_full, rx_empty, tx_full, tx_empty};
      REG_PRESCALE: rd_mux = {16'b0, prescale};
      REG_RXDATA:   rd_mux = {23'b0, ~rx_empty, (rx_empty ? 8'h00 : rx_mem[rx_rp])};
      REG_LEVEL:    rd_mux = {16'b0, 8'(rx_cnt), 8'(tx_cnt)};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (tx_push_ok) tx_mem[tx_wp] <= bram_wr_data[11:0];
    if (rx_push_ok) rx_mem[rx_wp] <= rsp_data;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      bram_rd_data <= '0;
      core_en      <= 1'b0;
      prescale     <= 16'h00FF;
      tx_wp        <= '0;
      tx_rp        <= '0;
      tx_cnt       <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_cnt       <= '0;
      tx_ovf       <= 1'b0;
      rx_ovf       <= 1'b0;
    end else begin
      if (ctrl_wr)     core_en  <= bram_wr_data[0];
      if (prescale_wr) prescale <= bram_wr_data[15:0];
      if (rd_en)       bram_rd_data <= rd_mux;

      if (tx_clr) begin
        tx_wp  <= '0;
        tx_rp  <= '0;
        tx_cnt <= '0;
      end else begin
        if (tx_push_ok) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)     tx_rp <= tx_rp + 1'b1;
        tx_cnt <= tx_cnt + CW'(tx_push_ok) - CW'(tx_pop);
      end

      if (rx_clr) begin
        rx_wp  <= '0;
        rx_rp  <= '0;
        rx_cnt <= '0;
      end else begin
        if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)     rx_rp <= rx_rp + 1'b1;
        rx_cnt <= rx_cnt + CW'(rx_push_ok) - CW'(rx_pop);
      end

      // New overflow takes priority over a same-cycle W1C so the event is never lost.
      if (tx_push && tx_full)                  tx_ovf <= 1'b1;
      else if (status_wr && bram_wr_data[6])   tx_ovf <= 1'b0;
      if (rsp_valid && rx_full)                rx_ovf <= 1'b1;
      else if (status_wr && bram_wr_data[5])   rx_ovf <= 1'b0;
    end
  end

`ifdef I2C_CSR_IRQ_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= bram_wr_data[3];
      irq <= irq_en & (~rx_empty | tx_ovf | rx_ovf | (tx_empty & ~engine_busy));
    end
  end
  assign unused_bits = ^{bram_wr_data[31:16], bram_addr[ADD_WIDTH-1:5], bram_addr[1:0]};
`else
  assign irq_en      = 1'b0;
  assign irq         = 1'b0;
  assign unused_bits = ^{bram_wr_data[31:16], bram_wr_data[3], bram_addr[ADD_WIDTH-1:5], bram_addr[1:0]};
`endif

endmodule
